// File: rtl/ptc_pkg.sv
// Shared types and constants for the perceptron training controller.
// Build option: define PTC_WEIGHT_SAT_EN to saturate weight/bias updates
// instead of letting them wrap modulo 2^14.
package ptc_pkg;

  localparam int W_WIDTH    = 14;  // Q5.8 weights and bias
  localparam int X_WIDTH    = 7;   // Q3.4 sample features
  localparam int FRAC_ALIGN = 4;   // Q3.4 -> Q5.8 fraction alignment

  localparam logic [1:0]         SIGN_POS = 2'b01;
  localparam logic [1:0]         SIGN_NEG = 2'b11;
  localparam logic [W_WIDTH-1:0] ONE_Q58  = 14'd256;

  typedef enum logic [2:0] {
    IDLE, FETCH, LATCH, EVAL, UPDATE, NEXT, DONE
  } state_e;

  // Weight/bias update step: a +/- d, either saturating or wrapping.
  function automatic logic [W_WIDTH-1:0] upd_step(input logic [W_WIDTH-1:0] a,
                                                  input logic [W_WIDTH-1:0] d,
                                                  input logic               sub);
`ifdef PTC_WEIGHT_SAT_EN
    logic signed [W_WIDTH:0] s;
    s = sub ? ((W_WIDTH+1)'($signed(a)) - (W_WIDTH+1)'($signed(d)))
            : ((W_WIDTH+1)'($signed(a)) + (W_WIDTH+1)'($signed(d)));
    // One extra bit disagreeing with the sign bit means the result left range.
    if (s[W_WIDTH] != s[W_WIDTH-1])
      return s[W_WIDTH] ? {1'b1, {(W_WIDTH-1){1'b0}}} : {1'b0, {(W_WIDTH-1){1'b1}}};
    return s[W_WIDTH-1:0];
`else
    return sub ? (a - d) : (a + d);
`endif
  endfunction

endpackage

// File: rtl/perceptron_eval.sv
// Combinational 2-input fixed-point perceptron classifier.
// yin = x1*w1 + x2*w2 + b, products realigned to Q5.8; the sum always wraps.
module perceptron_eval
  import ptc_pkg::*;
(
  input  logic signed [X_WIDTH-1:0] x1,
  input  logic signed [X_WIDTH-1:0] x2,
  input  logic signed [W_WIDTH-1:0] w1,
  input  logic signed [W_WIDTH-1:0] w2,
  input  logic signed [W_WIDTH-1:0] b,
  input  logic                      t,
  output logic [1:0]                sign,
  output logic                      mismatch
);

  logic signed [27:0]        prod1, prod2;
  logic        [W_WIDTH-1:0] yin;

  assign prod1 = 28'(x1) * 28'(w1);
  assign prod2 = 28'(x2) * 28'(w2);

  // Drop the 4 extra fraction bits of each product, keep bits [17:4].
  assign yin = 14'(prod1 >>> FRAC_ALIGN) + 14'(prod2 >>> FRAC_ALIGN) + b;

  assign sign     = yin[W_WIDTH-1] ? SIGN_NEG : SIGN_POS;
  assign mismatch = (sign[1] != t);

endmodule

// File: rtl/perceptron_train_ctrl.sv
// Perceptron training sequencer: walks the sample store epoch by epoch,
// classifies each sample and applies the perceptron rule on a mismatch.
// Build option: PTC_WEIGHT_SAT_EN selects saturating weight updates.
module perceptron_train_ctrl
  import ptc_pkg::*;
#(
  parameter int N_SAMPLES = 4,
  parameter int MAX_EPOCH = 16,
  parameter int LR_SHIFT  = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [W_WIDTH-1:0] init_w1,
  input  logic [W_WIDTH-1:0] init_w2,
  input  logic [W_WIDTH-1:0] init_b,
  output logic [7:0]         smp_addr,
  input  logic [X_WIDTH-1:0] smp_x1,
  input  logic [X_WIDTH-1:0] smp_x2,
  input  logic               smp_t,
  output logic [W_WIDTH-1:0] w1,
  output logic [W_WIDTH-1:0] w2,
  output logic [W_WIDTH-1:0] b,
  output logic               busy,
  output logic               done,
  output logic               converged,
  output logic [7:0]         epoch_cnt,
  output logic [7:0]         err_cnt
);

  state_e                    state_q, state_d;
  logic [W_WIDTH-1:0]        w1_q, w1_d, w2_q, w2_d, b_q, b_d;
  logic signed [X_WIDTH-1:0] x1_q, x1_d, x2_q, x2_d;
  logic                      t_q, t_d, mis_q, mis_d, neg_q, neg_d, conv_q, conv_d;
  logic [7:0]                addr_q, addr_d, epoch_q, epoch_d, err_q, err_d;
  logic [1:0]                sign_w;
  logic                      mis_w;
  logic signed [W_WIDTH-1:0] d1, d2;
  logic [W_WIDTH-1:0]        db;

  perceptron_eval u_eval (
    .x1(x1_q), .x2(x2_q), .w1(w1_q), .w2(w2_q), .b(b_q), .t(t_q),
    .sign(sign_w), .mismatch(mis_w)
  );

  // Learning-rate scaled deltas: features realigned to Q5.8, then shifted.
  assign d1 = (W_WIDTH'(x1_q) <<< FRAC_ALIGN) >>> LR_SHIFT;
  assign d2 = (W_WIDTH'(x2_q) <<< FRAC_ALIGN) >>> LR_SHIFT;
  assign db = ONE_Q58 >> LR_SHIFT;

  // Next-state and datapath updates for the training sequence.
  always_comb begin
    state_d = state_q;
    w1_d    = w1_q;
    w2_d    = w2_q;
    b_d     = b_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    t_d     = t_q;
    mis_d   = mis_q;
    neg_d   = neg_q;
    conv_d  = conv_q;
    addr_d  = addr_q;
    epoch_d = epoch_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (start) begin
        w1_d    = init_w1;
        w2_d    = init_w2;
        b_d     = init_b;
        epoch_d = '0;
        err_d   = '0;
        conv_d  = 1'b0;
        addr_d  = '0;
        state_d = FETCH;
      end
      FETCH: state_d = LATCH;
      LATCH: begin
        x1_d    = $signed(smp_x1);
        x2_d    = $signed(smp_x2);
        t_d     = smp_t;
        state_d = EVAL;
      end
      EVAL: begin
        mis_d   = mis_w;
        neg_d   = (sign_w == SIGN_NEG);
        state_d = UPDATE;
      end
      UPDATE: begin
        // On a mismatch the prediction is opposite to the target, so moving
        // away from the predicted sign is the perceptron rule (t=0 adds).
        if (mis_q) begin
          w1_d  = upd_step(w1_q, d1, !neg_q);
          w2_d  = upd_step(w2_q, d2, !neg_q);
          b_d   = upd_step(b_q,  db, !neg_q);
          err_d = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
        end
        state_d = NEXT;
      end
      NEXT: begin
        if (addr_q != 8'(N_SAMPLES - 1)) begin
          addr_d  = addr_q + 8'd1;
          state_d = FETCH;
        end else begin
          epoch_d = epoch_q + 8'd1;
          if (err_q == 8'd0) begin
            conv_d  = 1'b1;
            state_d = DONE;
          end else if (epoch_q + 8'd1 == 8'(MAX_EPOCH)) begin
            conv_d  = 1'b0;
            state_d = DONE;
          end else begin
            addr_d  = '0;
            err_d   = '0;
            state_d = FETCH;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, all cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      w1_q    <= '0;
      w2_q    <= '0;
      b_q     <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      t_q     <= 1'b0;
      mis_q   <= 1'b0;
      neg_q   <= 1'b0;
      conv_q  <= 1'b0;
      addr_q  <= '0;
      epoch_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      b_q     <= b_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      t_q     <= t_d;
      mis_q   <= mis_d;
      neg_q   <= neg_d;
      conv_q  <= conv_d;
      addr_q  <= addr_d;
      epoch_q <= epoch_d;
      err_q   <= err_d;
    end
  end

  assign smp_addr  = addr_q;
  assign w1        = w1_q;
  assign w2        = w2_q;
  assign b         = b_q;
  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign done      = (state_q == DONE);
  assign converged = conv_q;
  assign epoch_cnt = epoch_q;
  assign err_cnt   = err_q;

endmodule
